// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave cook sequencer.
package mw_pkg;

    localparam int unsigned BCD_W  = 4;
    localparam int unsigned TIME_W = 4 * BCD_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } mw_state_e;

    localparam logic [BCD_W-1:0] POWER_FULL   = BCD_W'(10);
    localparam logic [BCD_W-1:0] BCD_MAX_ONES = BCD_W'(9);
    localparam logic [BCD_W-1:0] BCD_MAX_TENS = BCD_W'(5);

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

endpackage

// File: rtl/mw_bcd_countdown.sv
// mm:ss BCD time register: shift-in digit load, borrow-chained decrement,
// registered zero / one-second-left flags.
module mw_bcd_countdown
    import mw_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] digit_i,
    input  logic             dec_i,
    output bcd_time_t        time_o,
    output logic             zero_o,
    output logic             last_o
);

    bcd_time_t time_q, time_d;
    logic      zero_q, last_q;
    logic      borrow_so, borrow_st, borrow_mo;

    // Priority: clear > load > decrement.
    always_comb begin
        time_d    = time_q;
        borrow_so = 1'b0;
        borrow_st = 1'b0;
        borrow_mo = 1'b0;
        if (clr_i) begin
            time_d = '0;
        end else if (load_i) begin
            time_d.min_tens = time_q.min_ones;
            time_d.min_ones = time_q.sec_tens;
            time_d.sec_tens = time_q.sec_ones;
            time_d.sec_ones = digit_i;
        end else if (dec_i) begin
            if (time_q.sec_ones == '0) begin
                time_d.sec_ones = BCD_MAX_ONES;
                borrow_so       = 1'b1;
            end else begin
                time_d.sec_ones = time_q.sec_ones - BCD_W'(1);
            end
            if (borrow_so) begin
                if (time_q.sec_tens == '0) begin
                    time_d.sec_tens = BCD_MAX_TENS;
                    borrow_st       = 1'b1;
                end else begin
                    time_d.sec_tens = time_q.sec_tens - BCD_W'(1);
                end
            end
            if (borrow_st) begin
                if (time_q.min_ones == '0) begin
                    time_d.min_ones = BCD_MAX_ONES;
                    borrow_mo       = 1'b1;
                end else begin
                    time_d.min_ones = time_q.min_ones - BCD_W'(1);
                end
            end
            if (borrow_mo) begin
                time_d.min_tens = time_q.min_tens - BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            time_q <= '0;
            zero_q <= 1'b1;
            last_q <= 1'b0;
        end else begin
            time_q <= time_d;
            zero_q <= (time_d == TIME_W'(0));
            last_q <= (time_d == TIME_W'(1));
        end
    end

    assign time_o = time_q;
    assign zero_o = zero_q;
    assign last_o = last_q;

endmodule

// File: rtl/mw_cook_sequencer.sv
// Microwave cook sequencer: keypad entry, IDLE/ENTRY/COOK/PAUSE/DONE control,
// one-second tick, power-level duty cycle on the magnetron and end beep.
module mw_cook_sequencer
    import mw_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             key_strobe,
    input  logic             power_strobe,
    input  logic [BCD_W-1:0] key_digit,
    output logic             mag_on,
    output logic             beep,
    output logic [2:0]       state,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens
);

    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    mw_state_e         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BCD_W-1:0]  phase_q, phase_d;
    logic [BCD_W-1:0]  power_q, power_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              start_prev_q, stop_prev_q;
    logic              mag_on_q, mag_on_d;
    logic              beep_q, beep_d;

    logic              start_ev, stop_ev, tick, digit_ok;
    logic              cd_clr, cd_load, cd_dec, time_zero, time_last;
    logic [BCD_W-1:0]  phase_inc;
    bcd_time_t         cook_time;

    assign start_ev  = start_prev_q & ~startn;
    assign stop_ev   = stop_prev_q & ~stopn;
    assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
    assign digit_ok  = (key_digit <= BCD_MAX_ONES);
    assign phase_inc = (phase_q == BCD_MAX_ONES) ? '0 : phase_q + BCD_W'(1);

    mw_bcd_countdown u_countdown (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (cd_clr),
        .load_i  (cd_load),
        .digit_i (key_digit),
        .dec_i   (cd_dec),
        .time_o  (cook_time),
        .zero_o  (time_zero),
        .last_o  (time_last)
    );

    // Next-state logic; within a state, branch order encodes event priority.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        phase_d    = phase_q;
        power_d    = power_q;
        beep_cnt_d = beep_cnt_q;
        cd_clr     = 1'b0;
        cd_load    = 1'b0;
        cd_dec     = 1'b0;
        if (!clearn) begin
            state_d    = ST_IDLE;
            cd_clr     = 1'b1;
            power_d    = POWER_FULL;
            div_d      = '0;
            phase_d    = '0;
            beep_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (start_ev && state_q == ST_ENTRY && door_closed && !time_zero) begin
                        state_d = ST_COOK;
                        div_d   = '0;
                        phase_d = '0;
                    end else begin
                        if (key_strobe && digit_ok) begin
                            cd_load = 1'b1;
                            state_d = ST_ENTRY;
                        end
                        if (power_strobe && digit_ok) begin
                            power_d = (key_digit == '0) ? POWER_FULL : key_digit;
                        end
                    end
                end
                ST_COOK: begin
                    // A tick landing on a pause is dropped; divider and phase hold.
                    if (!door_closed || stop_ev) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        cd_dec  = 1'b1;
                        div_d   = '0;
                        phase_d = phase_inc;
                        if (time_last) begin
                            state_d    = ST_DONE;
                            beep_cnt_d = '0;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (stop_ev) begin
                        state_d = ST_IDLE;
                        cd_clr  = 1'b1;
                    end else if (start_ev && door_closed && !time_zero) begin
                        state_d = ST_COOK;
                        div_d   = '0;
                        phase_d = '0;
                    end
                end
                ST_DONE: begin
                    if (key_strobe || start_ev) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        div_d = '0;
                        if (beep_cnt_q == BEEP_W'(BEEP_SECS - 1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        mag_on_d = (state_d == ST_COOK) && (phase_d < power_d);
        beep_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            phase_q      <= '0;
            power_q      <= POWER_FULL;
            beep_cnt_q   <= '0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            mag_on_q     <= 1'b0;
            beep_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            power_q      <= power_d;
            beep_cnt_q   <= beep_cnt_d;
            start_prev_q <= startn;
            stop_prev_q  <= stopn;
            mag_on_q     <= mag_on_d;
            beep_q       <= beep_d;
        end
    end

    assign mag_on   = mag_on_q;
    assign beep     = beep_q;
    assign state    = state_q;
    assign sec_ones = cook_time.sec_ones;
    assign sec_tens = cook_time.sec_tens;
    assign min_ones = cook_time.min_ones;
    assign min_tens = cook_time.min_tens;

endmodule

// File: tb/tb_mw_cook_sequencer.sv
// Directed bench for mw_cook_sequencer with a 4-cycle tick and 3-tick beep.
module tb_mw_cook_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       startn, stopn, clearn, door_closed;
    logic       key_strobe, power_strobe;
    logic [3:0] key_digit;
    logic       mag_on, beep;
    logic [2:0] state;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] S_IDLE  = 16'd0;
    localparam logic [15:0] S_ENTRY = 16'd1;
    localparam logic [15:0] S_COOK  = 16'd2;
    localparam logic [15:0] S_PAUSE = 16'd3;
    localparam logic [15:0] S_DONE  = 16'd4;

    mw_cook_sequencer #(.TICK_DIV(4), .BEEP_SECS(3)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .startn       (startn),
        .stopn        (stopn),
        .clearn       (clearn),
        .door_closed  (door_closed),
        .key_strobe   (key_strobe),
        .power_strobe (power_strobe),
        .key_digit    (key_digit),
        .mag_on       (mag_on),
        .beep         (beep),
        .state        (state),
        .sec_ones     (sec_ones),
        .sec_tens     (sec_tens),
        .min_ones     (min_ones),
        .min_tens     (min_tens)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tnow();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic key(input logic [3:0] d);
        key_digit = d; key_strobe = 1'b1; step(); key_strobe = 1'b0;
    endtask

    task automatic pwr(input logic [3:0] d);
        key_digit = d; power_strobe = 1'b1; step(); power_strobe = 1'b0;
    endtask

    task automatic start();
        startn = 1'b0; step(); startn = 1'b1;
    endtask

    task automatic stop();
        stopn = 1'b0; step(); stopn = 1'b1;
    endtask

    task automatic clear();
        clearn = 1'b0; step(); clearn = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rstn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
        key_strobe = 1'b0; power_strobe = 1'b0; key_digit = 4'd0;
        steps(2);
        check("rst_state", 16'(state), S_IDLE);
        check("rst_time", tnow(), 16'h0000);
        check("rst_mag", 16'(mag_on), 16'd0);
        check("rst_beep", 16'(beep), 16'd0);
        rstn = 1'b1;
        step();

        // Entry 1,3,0 -> 01:30, invalid digit ignored, power 5 duty
        key(4'd1);
        check("entry1_state", 16'(state), S_ENTRY);
        check("entry1_time", tnow(), 16'h0001);
        key(4'd3);
        check("entry2_time", tnow(), 16'h0013);
        key(4'd0);
        check("entry3_time", tnow(), 16'h0130);
        key(4'd12);
        check("bad_digit", tnow(), 16'h0130);
        pwr(4'd5);
        start();
        check("start_state", 16'(state), S_COOK);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("duty_k%0d", k), 16'(mag_on), (((k / 4) % 10) < 5) ? 16'd1 : 16'd0);
            step();
        end
        check("duty_time", tnow(), 16'h0120);
        clear();
        check("clr_state", 16'(state), S_IDLE);
        check("clr_time", tnow(), 16'h0000);
        check("clr_mag", 16'(mag_on), 16'd0);

        // Zero time start ignored; 00:02 at full power runs to DONE and beep
        key(4'd0);
        check("zero_entry_state", 16'(state), S_ENTRY);
        start();
        check("zero_start_ign", 16'(state), S_ENTRY);
        key(4'd2);
        check("t2_time", tnow(), 16'h0002);
        start();
        check("t2_cook", 16'(state), S_COOK);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("full_mag_k%0d", k), 16'(mag_on), 16'd1);
            if (k == 4) check("t2_one", tnow(), 16'h0001);
            step();
        end
        check("done_state", 16'(state), S_DONE);
        check("done_mag", 16'(mag_on), 16'd0);
        check("done_time", tnow(), 16'h0000);
        for (int d = 0; d < 12; d++) begin
            check($sformatf("beep_d%0d", d), 16'(beep), 16'd1);
            step();
        end
        check("beep_off", 16'(beep), 16'd0);
        check("beep_idle", 16'(state), S_IDLE);

        // Borrow chains
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        start(); steps(4);
        check("borrow_1000", tnow(), 16'h0959);
        clear();
        key(4'd1); key(4'd0); key(4'd0);
        start(); steps(4);
        check("borrow_0100", tnow(), 16'h0059);
        clear();
        key(4'd9); key(4'd9);
        start(); steps(4);
        check("sec99", tnow(), 16'h0098);
        clear();

        // Door open pause and resume
        key(4'd4); key(4'd7);
        start(); steps(8);
        check("pre_door", tnow(), 16'h0045);
        door_closed = 1'b0;
        step();
        check("door_pause", 16'(state), S_PAUSE);
        check("door_mag", 16'(mag_on), 16'd0);
        steps(10);
        check("pause_frozen", tnow(), 16'h0045);
        start();
        check("start_door_open", 16'(state), S_PAUSE);
        door_closed = 1'b1;
        step();
        start();
        check("resume_state", 16'(state), S_COOK);
        check("resume_mag", 16'(mag_on), 16'd1);
        check("resume_time", tnow(), 16'h0045);
        steps(4);
        check("resume_tick", tnow(), 16'h0044);

        // Stop on a tick cycle: pause without decrement, then stop clears
        steps(3);
        stop();
        check("stop_pause", 16'(state), S_PAUSE);
        check("stop_no_dec", tnow(), 16'h0044);
        step();
        stop();
        check("stop2_state", 16'(state), S_IDLE);
        check("stop2_time", tnow(), 16'h0000);

        // Asynchronous reset mid-cook
        key(4'd5);
        start(); steps(2);
        check("pre_rst_cook", 16'(state), S_COOK);
        #2 rstn = 1'b0;
        #1;
        check("arst_state", 16'(state), S_IDLE);
        check("arst_time", tnow(), 16'h0000);
        check("arst_mag", 16'(mag_on), 16'd0);
        rstn = 1'b1;
        step();
        check("post_rst_state", 16'(state), S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
